// File: rtl/copper2.sv
// copper2 -- display-list coprocessor. It steps through a small instruction
// list in lock-step with the beam. It can wait on beam position, skip, jump,
// change the background colour and issue writes to graphics registers.
// It also produces the panned/flipped beam coordinates for downstream.
// Build option: define COPPER2_LOOP_EN to add LOOPSET (0xA) / LOOP (0xB).
module copper2 #(
  parameter int          LIST_BITS  = 9,
  parameter int          COORD_BITS = 10,
  parameter logic [11:0] LIST_BASE  = 12'h400,
  parameter logic [11:0] CTRL_BASE  = 12'hd20
) (
  input  logic                  CLK,
  input  logic                  RSTb,
  input  logic [11:0]           ADDRESS,
  input  logic [15:0]           DATA_IN,
  input  logic                  WR,
  input  logic                  V_tick,
  input  logic                  H_tick,
  input  logic [COORD_BITS-1:0] display_x,
  input  logic [COORD_BITS-1:0] display_y,
  output logic [11:0]           COPPER_ADDRESS,
  output logic                  COPPER_WR,
  output logic [15:0]           COPPER_DATA_OUT,
  output logic [11:0]           background_color,
  output logic [COORD_BITS-1:0] display_x_out,
  output logic [COORD_BITS-1:0] display_y_out,
  output logic                  halted
);

  localparam int DEPTH = 1 << LIST_BITS;

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, WAIT_V, WAIT_H, WRITE_DATA, HALT} state_t;
  typedef logic [LIST_BITS-1:0]  pc_t;
  typedef logic [COORD_BITS-1:0] crd_t;

  // one-hot-ish decode of the host write target
  typedef struct packed {
    logic en;
    logic yf;
    logic bg;
    logic xp;
    logic lst;
  } hsel_t;

  state_t      state, state_n;
  pc_t         pc, pc_n;
  crd_t        tgt, tgt_n;
  logic        wr_pend, pend_n;
  logic        enable;
  crd_t        yf_line, x_pan;
  logic        yf_en;
  logic [15:0] mem [DEPTH];
  logic [15:0] ins;
  logic [3:0]  opc;
  crd_t        op;
  logic [11:0] caddr_n;
  logic [15:0] cdata_n;
  logic        cwr_n;
  logic        bg_ex;
  hsel_t       hsel;
  logic [11:0] list_off;
  crd_t        dy_n;
`ifdef COPPER2_LOOP_EN
  logic [11:0] cnt, cnt_n;
`endif

  // H_tick only matters for event ordering; V_tick already outranks it
  logic unused_h;
  assign unused_h = H_tick;

  assign opc    = ins[15:12];
  assign op     = crd_t'(ins[11:0]);
  assign halted = (state == HALT);

  // decode which host-visible location a write targets
  always_comb begin
    list_off = ADDRESS - LIST_BASE;
    hsel.en  = WR && (ADDRESS == CTRL_BASE);
    hsel.yf  = WR && (ADDRESS == CTRL_BASE + 12'd1);
    hsel.bg  = WR && (ADDRESS == CTRL_BASE + 12'd2);
    hsel.xp  = WR && (ADDRESS == CTRL_BASE + 12'd3);
    hsel.lst = WR && (ADDRESS >= LIST_BASE) && ((list_off >> LIST_BITS) == 12'd0);
  end

  // list RAM: host write port, registered read at pc (old data on collision)
  always_ff @(posedge CLK) begin
    if (hsel.lst) mem[list_off[LIST_BITS-1:0]] <= DATA_IN;
    ins <= mem[pc];
  end

  // sequencer next-state and datapath next values
  always_comb begin
    state_n = state;
    pc_n    = pc;
    tgt_n   = tgt;
    pend_n  = wr_pend;
    caddr_n = COPPER_ADDRESS;
    cdata_n = COPPER_DATA_OUT;
    cwr_n   = 1'b0;
    bg_ex   = 1'b0;
`ifdef COPPER2_LOOP_EN
    cnt_n   = cnt;
`endif
    if (V_tick) begin
      // frame start restarts the list from the top
      pc_n    = '0;
      pend_n  = 1'b0;
      state_n = enable ? FETCH : IDLE;
    end else if (!enable) begin
      // disabled: park, keep pc, drop any half-issued write
      state_n = IDLE;
      pend_n  = 1'b0;
    end else begin
      case (state)
        IDLE:  state_n = FETCH;
        FETCH: state_n = wr_pend ? WRITE_DATA : EXEC;
        EXEC: begin
          state_n = FETCH;
          pc_n    = pc + pc_t'(1);
          case (opc)
            4'h1: pc_n = ins[LIST_BITS-1:0];
            4'h2: begin tgt_n = op; pc_n = pc; state_n = WAIT_V; end
            4'h3: begin tgt_n = op; pc_n = pc; state_n = WAIT_H; end
            4'h4: if (display_y >= op) pc_n = pc + pc_t'(2);
            4'h5: if (display_x >= op) pc_n = pc + pc_t'(2);
            4'h6: begin
              // colour change, then hold until the next line
              bg_ex   = 1'b1;
              tgt_n   = display_y + crd_t'(1);
              pc_n    = pc;
              state_n = WAIT_V;
            end
            4'h7: begin tgt_n = display_y + op; pc_n = pc; state_n = WAIT_V; end
            4'h8: begin tgt_n = display_x + op; pc_n = pc; state_n = WAIT_H; end
            4'h9: begin caddr_n = ins[11:0]; pend_n = 1'b1; end
`ifdef COPPER2_LOOP_EN
            4'ha: cnt_n = ins[11:0];
            4'hb: if (cnt != 12'd0) begin
              cnt_n = cnt - 12'd1;
              pc_n  = ins[LIST_BITS-1:0];
            end
`endif
            4'hf: begin pc_n = pc; state_n = HALT; end
            default: ;
          endcase
        end
        WAIT_V: if (display_y >= tgt) begin
          pc_n    = pc + pc_t'(1);
          state_n = FETCH;
        end
        WAIT_H: if (display_x >= tgt) begin
          pc_n    = pc + pc_t'(1);
          state_n = FETCH;
        end
        WRITE_DATA: begin
          // the word after a WRITE opcode is the payload
          cdata_n = ins;
          cwr_n   = 1'b1;
          pend_n  = 1'b0;
          pc_n    = pc + pc_t'(1);
          state_n = FETCH;
        end
        HALT:    state_n = HALT;
        default: state_n = IDLE;
      endcase
    end
  end

  // beam coordinate post-processing: mirror below the flip line
  always_comb begin
    dy_n = display_y;
    if (yf_en && (display_y >= yf_line)) dy_n = (yf_line << 1) - display_y;
  end

  // state and register file update
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      state            <= IDLE;
      pc               <= '0;
      tgt              <= '0;
      wr_pend          <= 1'b0;
      enable           <= 1'b0;
      yf_line          <= '0;
      yf_en            <= 1'b0;
      x_pan            <= '0;
      background_color <= 12'hf00;
      COPPER_ADDRESS   <= '0;
      COPPER_DATA_OUT  <= '0;
      COPPER_WR        <= 1'b0;
      display_x_out    <= '0;
      display_y_out    <= '0;
`ifdef COPPER2_LOOP_EN
      cnt              <= '0;
`endif
    end else begin
      state           <= state_n;
      pc              <= pc_n;
      tgt             <= tgt_n;
      wr_pend         <= pend_n;
      COPPER_ADDRESS  <= caddr_n;
      COPPER_DATA_OUT <= cdata_n;
      COPPER_WR       <= cwr_n;
      display_x_out   <= display_x + x_pan;
      display_y_out   <= dy_n;
`ifdef COPPER2_LOOP_EN
      cnt             <= cnt_n;
`endif
      if (hsel.en) enable <= DATA_IN[0];
      if (hsel.yf) begin
        yf_line <= DATA_IN[COORD_BITS-1:0];
        yf_en   <= DATA_IN[15];
      end
      if (hsel.xp) x_pan <= DATA_IN[COORD_BITS-1:0];
      // the list's own colour change outranks a simultaneous host write
      if (bg_ex)        background_color <= ins[11:0];
      else if (hsel.bg) background_color <= DATA_IN[11:0];
    end
  end

endmodule

// File: doc/copper2.md
COPPER2 -- requirements
Module: copper2

Interface
REQ-001 Parameter LIST_BITS, default 9, sets the list depth to 2^LIST_BITS 16-bit words.
REQ-002 Parameter COORD_BITS, default 10, sets the width of the display coordinates and wait operands.
REQ-003 Parameter LIST_BASE, default 12'h400, is the host address of list word 0.
REQ-004 Parameter CTRL_BASE, default 12'hd20, is the base address of the four control registers.
REQ-005 CLK  in  1  clock; RSTb  in  1  reset, synchronous, active-low.
REQ-006 ADDRESS  in  12, DATA_IN  in  16, WR  in  1: host write port, one write per WR-high cycle.
REQ-007 V_tick  in  1 (frame start pulse); H_tick  in  1 (line start pulse, unused except by REQ-013 ordering).
REQ-008 display_x, display_y  in  COORD_BITS: beam position.
REQ-009 COPPER_ADDRESS  out  12, COPPER_WR  out  1, COPPER_DATA_OUT  out  16: gfx register write port.
REQ-010 background_color  out  12; display_x_out, display_y_out  out  COORD_BITS; halted  out  1 (high in HALT).

Function
REQ-011 Host writes: CTRL_BASE+0 bit0 = enable; +1 bits[COORD_BITS-1:0] = yflip line, bit15 = yflip enable; +2 bits[11:0] = background colour; +3 = x_pan; LIST_BASE..LIST_BASE+2^LIST_BITS-1 = list word at the offset.
REQ-012 The list SHALL be a single-port-write, synchronous-read RAM, 1-cycle read latency, fetched at pc.
REQ-013 States: IDLE, FETCH, EXEC, WAIT_V, WAIT_H, WRITE_DATA, HALT; V_tick has priority over all other events: pc<=0 and state<=FETCH if enable else IDLE.
REQ-014 IDLE -> FETCH when enable=1; FETCH is 1 cycle; EXEC decodes ins[15:12]; operand op = ins[11:0] resized to COORD_BITS.
REQ-015 Opcode 0 NOP: pc+1, FETCH; undefined opcodes behave as NOP.
REQ-016 Opcode 1 JUMP: pc<=ins[LIST_BITS-1:0], FETCH.
REQ-017 Opcodes 2/3 WAITV/WAITH: target<=op; stay in WAIT_V/WAIT_H until display_y/display_x >= target, then pc+1, FETCH.
REQ-018 Opcodes 7/8: relative waits, target<=display_y/display_x + op, truncated to COORD_BITS (wraps).
REQ-019 Opcodes 4/5 SKIPV/SKIPH: pc+2 if display_y/display_x >= op else pc+1; FETCH.
REQ-020 Opcode 6 BG: background_color<=ins[11:0] at EXEC+1; target<=display_y+1; WAIT_V.
REQ-021 Opcode 9 WRITE: COPPER_ADDRESS<=ins[11:0]; pc+1; FETCH then WRITE_DATA: COPPER_DATA_OUT<=fetched word, COPPER_WR high exactly one cycle, pc+1, FETCH.
REQ-022 Opcode 15 STOP: HALT until V_tick.
REQ-023 All pc arithmetic SHALL wrap modulo 2^LIST_BITS.
REQ-024 Clearing enable forces IDLE next cycle; no COPPER_WR thereafter; pc is held.
REQ-025 Host BG write and opcode 6 in the same cycle: opcode 6 wins.
REQ-026 Host list write to the word being fetched: the fetch returns the old word; the new word is seen on the next fetch.
REQ-027 display_y_out, registered 1 cycle: 2*yflip - display_y (truncated) when yflip enabled and display_y >= yflip, else display_y.
REQ-028 display_x_out, registered 1 cycle: display_x + x_pan, truncated.

Reset
REQ-029 On RSTb=0 at CLK edge: state IDLE, pc 0, enable 0, yflip 0/off, x_pan 0, loop count 0, background_color 12'hf00, COPPER_* 0, display outs 0, halted 0.

Configuration
REQ-030 Macro COPPER2_LOOP_EN defined: opcode 10 LOOPSET sets a 12-bit count<=ins[11:0], pc+1; opcode 11 LOOP: if count != 0 then count-1 and pc<=ins[LIST_BITS-1:0], else pc+1; both go to FETCH.
REQ-031 COPPER2_LOOP_EN undefined: opcodes 10/11 behave as NOP and no count register exists.

Verification
REQ-032 List {9012, 0x0ABC, F000}, enable, V_tick -> one COPPER_WR pulse with addr 0x012, data 0x0ABC; halted=1.
REQ-033 List {2064, 6F0F, F000}, y steps 0..101 -> background_color 0xF0F once display_y>=100; WAIT_V until display_y=101.
REQ-034 LOOP_EN: {A003, 9005, 0x0001, B001, F000} -> exactly 4 COPPER_WR pulses to 0x005; without the macro, 1 pulse.
REQ-035 yflip 240 enabled, display_y=250 -> display_y_out=230; display_y=239 -> 239; x_pan 0x3FF, display_x=5 -> 4.
REQ-036 V_tick asserted mid-WAIT_H, and again in the cycle of a WRITE_DATA -> pc=0, FETCH; no pulse in the V_tick cycle; RSTb low mid-run -> all REQ-029 values.
